ysyx_23060025_axi_initiator: RTL and testbench
==============================================

YSYX_23060025_AXI_INITIATOR -- requirements
Module: ysyx_23060025_axi_initiator

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, meaning the data width of the request and AXI data channels.
REQ-002 SHALL have parameter ADDR_LEN, default 32, meaning the address width.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  in  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid_i  in  1  the core request is valid.
REQ-006 SHALL have port req_ready_o  out  1  the block accepts a request.
REQ-007 SHALL have port req_we_i  in  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr_i  in  ADDR_LEN  request address.
REQ-009 SHALL have port req_wdata_i  in  DATA_LEN  write data.
REQ-010 SHALL have port req_wstrb_i  in  4  write byte strobes.
REQ-011 SHALL have port resp_valid_o  out  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata_o  out  DATA_LEN  captured read data.
REQ-013 SHALL have port resp_err_o  out  1  error flag, valid together with resp_valid_o.
REQ-014 SHALL have port arvalid_o / arready_i  out/in  1/1  read-address handshake.
REQ-015 SHALL have port araddr_o  out  ADDR_LEN  read address.
REQ-016 SHALL have port rvalid_i / rready_o  in/out  1/1  read-data handshake.
REQ-017 SHALL have port rdata_i  in  DATA_LEN  read data.
REQ-018 SHALL have port rresp_i  in  2  read response.
REQ-019 SHALL have port awvalid_o / awready_i  out/in  1/1  write-address handshake.
REQ-020 SHALL have port awaddr_o  out  ADDR_LEN  write address.
REQ-021 SHALL have port wvalid_o / wready_i  out/in  1/1  write-data handshake.
REQ-022 SHALL have port wdata_o  out  DATA_LEN  write data.
REQ-023 SHALL have port wstrb_o  out  4  write strobes.
REQ-024 SHALL have port wlast_o  out  1  driven equal to wvalid_o (single beat).
REQ-025 SHALL have port bvalid_i / bready_o / bresp_i  in/out/in  1/1/2  write-response channel.
REQ-026 SHALL leave IDs, len, size and burst out of the port list; the parent ties them to id=0, len=0, size=3'b010, burst=INCR.

Function
REQ-027 SHALL implement FSM states IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
REQ-028 SHALL drive req_ready_o=1 only in IDLE, and SHALL capture addr, wdata, wstrb and we when req_valid_i&&req_ready_o.
REQ-029 SHALL move on a read accept from IDLE to RD_A with arvalid_o=1 and araddr_o=captured address held stable, and SHALL move to RD_D on the cycle after arvalid_o&&arready_i.
REQ-030 SHALL hold rready_o=1 in RD_D, and on rvalid_i SHALL capture rdata_i into resp_rdata_o, set err=rresp_i[1], and go to DONE.
REQ-031 SHALL move on a write accept from IDLE to WR_AW, asserting awvalid_o and wvalid_o in the same cycle.
REQ-032 SHALL drop awvalid_o and wvalid_o independently after their own handshake, tracked by aw_done and w_done flags, and SHALL handle either handshake first or both together.
REQ-033 SHALL go to WR_B once both aw_done and w_done are set, and there SHALL hold bready_o=1; on bvalid_i it SHALL set err=bresp_i[1] and go to DONE.
REQ-034 SHALL assert resp_valid_o for exactly one cycle in DONE, then return to IDLE.
REQ-035 SHALL keep resp_rdata_o unchanged by writes and hold it until the next read completes.
REQ-036 SHALL never deassert a valid before its handshake, and SHALL keep the payload stable while valid is high.
REQ-037 SHALL drive rready_o=0 and bready_o=0 outside RD_D/WR_B, and SHALL ignore rvalid_i and bvalid_i there.
REQ-038 SHALL achieve minimum read latency (arready and rvalid immediately): accept at T0, arvalid at T1, rready/rvalid at T2, resp_valid at T3.
REQ-039 SHALL treat rresp or bresp values of 2 or 3 as an error, and SHALL still complete normally.

Reset
REQ-040 SHALL, with rstn=0 at an edge, put state to IDLE, clear every valid/ready output except req_ready_o (1 after reset), clear resp_rdata_o, resp_err_o, aw_done and w_done, and produce no response, including when reset arrives mid-transaction.

Verification
REQ-041 SHALL cover: read 0x8000_0000 with arready=1 and rvalid at T2 carrying 0xDEAD_BEEF -> resp_valid at T3, rdata=0xDEAD_BEEF, err=0.
REQ-042 SHALL cover: write with wready 3 cycles before awready -> wvalid drops after its handshake, awvalid stays high, one bready phase, one resp pulse.
REQ-043 SHALL cover: arready held low for 5 cycles -> arvalid and araddr stable all 5 cycles, req_ready=0.
REQ-044 SHALL cover: read with rresp=2'b10 -> resp_err=1 and rdata captured; a following write with bresp=0 -> err=0 and rdata unchanged.
REQ-045 SHALL cover: rstn=0 during WR_B -> IDLE next cycle, all valids 0, no resp pulse, and a new read then completes correctly.

Source files
------------

// File: rtl/ysyx_23060025_axi_initiator.sv
// Single-outstanding AXI4 initiator: converts one core request at a time into an
// AXI read (AR/R) or single-beat write (AW/W/B) and returns a one-cycle completion pulse.
module ysyx_23060025_axi_initiator #(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                rstn,

    // core request / response
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_LEN-1:0] req_addr_i,
    input  logic [DATA_LEN-1:0] req_wdata_i,
    input  logic [3:0]          req_wstrb_i,
    output logic                resp_valid_o,
    output logic [DATA_LEN-1:0] resp_rdata_o,
    output logic                resp_err_o,

    // read address channel
    output logic                arvalid_o,
    input  logic                arready_i,
    output logic [ADDR_LEN-1:0] araddr_o,

    // read data channel
    input  logic                rvalid_i,
    output logic                rready_o,
    input  logic [DATA_LEN-1:0] rdata_i,
    input  logic [1:0]          rresp_i,

    // write address channel
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [ADDR_LEN-1:0] awaddr_o,

    // write data channel
    output logic                wvalid_o,
    input  logic                wready_i,
    output logic [DATA_LEN-1:0] wdata_o,
    output logic [3:0]          wstrb_o,
    output logic                wlast_o,

    // write response channel
    input  logic                bvalid_i,
    output logic                bready_o,
    input  logic [1:0]          bresp_i
);

    localparam int unsigned STRB_LEN = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4,
        DONE  = 3'd5
    } state_e;

    typedef struct packed {
        logic [ADDR_LEN-1:0] addr;
        logic [DATA_LEN-1:0] wdata;
        logic [STRB_LEN-1:0] wstrb;
    } req_t;

    state_e              state_q, state_d;
    req_t                req_q, req_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [DATA_LEN-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                req_ready_q, req_ready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                resp_valid_q, resp_valid_d;

    logic                aw_hs, w_hs;

    // Only bit 1 of a response (SLVERR/DECERR) matters; the OKAY/EXOKAY bit is dropped.
    logic                unused_resp_lsb;
    assign unused_resp_lsb = rresp_i[0] ^ bresp_i[0];

    assign aw_hs = awvalid_q && awready_i;
    assign w_hs  = wvalid_q && wready_i;

    // Next state, captured payload and next value of every registered output.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rdata_d      = rdata_q;
        err_d        = err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    req_d.addr  = req_addr_i;
                    req_d.wdata = req_wdata_i;
                    req_d.wstrb = req_wstrb_i;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    state_d     = req_we_i ? WR_AW : RD_A;
                end
            end
            RD_A: begin
                if (arvalid_q && arready_i) begin
                    state_d = RD_D;
                end
            end
            RD_D: begin
                if (rvalid_i) begin
                    rdata_d = rdata_i;
                    err_d   = rresp_i[1];
                    state_d = DONE;
                end
            end
            WR_AW: begin
                // AW and W complete independently, in either order or together.
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = WR_B;
                end
            end
            WR_B: begin
                if (bvalid_i) begin
                    err_d   = bresp_i[1];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d  = (state_d == IDLE);
        arvalid_d    = (state_d == RD_A);
        rready_d     = (state_d == RD_D);
        awvalid_d    = (state_d == WR_AW) && !aw_done_d;
        wvalid_d     = (state_d == WR_AW) && !w_done_d;
        bready_d     = (state_d == WR_B);
        resp_valid_d = (state_d == DONE);
    end

    // State, payload and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            req_q        <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

    assign arvalid_o    = arvalid_q;
    assign araddr_o     = req_q.addr;
    assign rready_o     = rready_q;

    assign awvalid_o    = awvalid_q;
    assign awaddr_o     = req_q.addr;
    assign wvalid_o     = wvalid_q;
    assign wdata_o      = req_q.wdata;
    assign wstrb_o      = req_q.wstrb;
    assign wlast_o      = wvalid_q;
    assign bready_o     = bready_q;

endmodule

// File: tb/tb_ysyx_23060025_axi_initiator.sv
// Self-checking bench: directed vector table, a reset-in-WR_B sequence and random
// transactions, with an AXI slave whose timing is set per transaction.
module tb_ysyx_23060025_axi_initiator;

    logic        clk;
    logic        rstn;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [3:0]  req_wstrb_i;
    logic        resp_valid_o, resp_err_o;
    logic [31:0] resp_rdata_o;
    logic        arvalid_o, arready_i;
    logic [31:0] araddr_o;
    logic        rvalid_i, rready_o;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        awvalid_o, awready_i;
    logic [31:0] awaddr_o;
    logic        wvalid_o, wready_i, wlast_o;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        bvalid_i, bready_o;
    logic [1:0]  bresp_i;

    ysyx_23060025_axi_initiator dut (
        .clk(clk), .rstn(rstn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .wlast_o(wlast_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ar_d;      // cycles arvalid waits before arready
        int          r_d;       // cycles rready waits before rvalid
        int          aw_d;
        int          w_d;
        int          b_d;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;   // cycles from accept edge to the resp_valid cycle
    } vec_t;

    int          checks;
    int          failures;
    logic [31:0] model_rdata;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = '0;
        awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = '0;
    endtask

    // Reference rules: latency = 3 + address-phase wait + response wait; errors on resp >= 2;
    // writes return whatever the last completed read captured.
    function automatic vec_t ref_model(input vec_t t, input logic [31:0] last_rdata);
        vec_t r;
        int   addr_wait;
        r = t;
        addr_wait   = t.we ? ((t.aw_d > t.w_d) ? t.aw_d : t.w_d) : t.ar_d;
        r.exp_lat   = 3 + addr_wait + (t.we ? t.b_d : t.r_d);
        r.exp_err   = (t.resp >= 2'd2);
        r.exp_rdata = t.we ? last_rdata : t.rdata;
        return r;
    endfunction

    task automatic run_txn(input vec_t t, input string tag);
        int   cyc, resp_cyc, viol;
        int   n_ar, n_r, n_aw, n_w, n_b;
        bit   ar_hs, r_hs, aw_hs, w_hs, b_hs, done;
        bit   e_arv, e_rr, e_awv, e_wv, e_br;
        bit   hs_ar, hs_r, hs_aw, hs_w, hs_b;
        logic [31:0] got_rdata;
        logic        got_err;
        {n_ar, n_r, n_aw, n_w, n_b} = '0;
        {ar_hs, r_hs, aw_hs, w_hs, b_hs, done} = '0;
        viol = 0; resp_cyc = 0; got_rdata = '0; got_err = 1'b0;

        @(negedge clk);
        chk({tag, ".req_ready"}, 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b1; req_we_i = t.we; req_addr_i = t.addr;
        req_wdata_i = t.wdata; req_wstrb_i = t.wstrb;
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        while (!done && cyc <= t.exp_lat + 20) begin
            e_arv = !t.we && !ar_hs;
            e_rr  = !t.we && ar_hs && !r_hs;
            e_awv = t.we && !aw_hs;
            e_wv  = t.we && !w_hs;
            e_br  = t.we && aw_hs && w_hs && !b_hs;
            if (arvalid_o !== e_arv || rready_o !== e_rr || awvalid_o !== e_awv ||
                wvalid_o !== e_wv || bready_o !== e_br || req_ready_o !== 1'b0)
                viol++;
            if (wlast_o !== wvalid_o) viol++;
            if (arvalid_o && araddr_o !== t.addr) viol++;
            if (awvalid_o && awaddr_o !== t.addr) viol++;
            if (wvalid_o && (wdata_o !== t.wdata || wstrb_o !== t.wstrb)) viol++;

            if (resp_valid_o === 1'b1) begin
                resp_cyc  = cyc;
                got_rdata = resp_rdata_o;
                got_err   = resp_err_o;
                done      = 1'b1;
            end else begin
                // requests while busy must be ignored
                req_valid_i = 1'($urandom); req_we_i = 1'($urandom);
                req_addr_i = $urandom; req_wdata_i = $urandom; req_wstrb_i = 4'($urandom);
                arready_i = arvalid_o ? (n_ar >= t.ar_d) : 1'($urandom);
                awready_i = awvalid_o ? (n_aw >= t.aw_d) : 1'($urandom);
                wready_i  = wvalid_o  ? (n_w  >= t.w_d)  : 1'($urandom);
                if (arvalid_o) n_ar++;
                if (awvalid_o) n_aw++;
                if (wvalid_o)  n_w++;
                if (e_rr) begin
                    rvalid_i = (n_r >= t.r_d);
                    rdata_i  = rvalid_i ? t.rdata : $urandom;
                    rresp_i  = t.resp;
                    n_r++;
                end else begin
                    rvalid_i = 1'($urandom); rdata_i = $urandom; rresp_i = 2'($urandom);
                end
                if (e_br) begin
                    bvalid_i = (n_b >= t.b_d);
                    bresp_i  = t.resp;
                    n_b++;
                end else begin
                    bvalid_i = 1'($urandom); bresp_i = 2'($urandom);
                end
                hs_ar = arvalid_o && arready_i;
                hs_r  = rready_o && rvalid_i && e_rr;
                hs_aw = awvalid_o && awready_i;
                hs_w  = wvalid_o && wready_i;
                hs_b  = bready_o && bvalid_i && e_br;
                @(posedge clk);
                ar_hs |= hs_ar; r_hs |= hs_r; aw_hs |= hs_aw; w_hs |= hs_w; b_hs |= hs_b;
                @(negedge clk);
                cyc++;
            end
        end
        req_valid_i = 1'b0;
        slave_idle();
        chk({tag, ".latency"}, 64'(resp_cyc), 64'(t.exp_lat));
        chk({tag, ".rdata"}, 64'(got_rdata), 64'(t.exp_rdata));
        chk({tag, ".err"}, 64'(got_err), 64'(t.exp_err));
        chk({tag, ".protocol_violations"}, 64'(viol), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".single_pulse"}, 64'({resp_valid_o, req_ready_o}), 64'b01);
    endtask

    initial begin
        vec_t t;
        int   quiet;
        checks = 0; failures = 0; model_rdata = '0;
        clk = 1'b0; rstn = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
        slave_idle();

        //           we    addr           wdata          strb  ar r aw w b resp   rdata          exp_rdata      err lat
        vecs[0] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[1] = '{1'b1, 32'h8000_0010, 32'hA5A5_5A5A, 4'hF, 0, 0, 3, 0, 1, 2'b00, 32'h0,         32'hDEAD_BEEF, 1'b0, 7};
        vecs[2] = '{1'b0, 32'h8000_1234, 32'h0,         4'h0, 5, 2, 0, 0, 0, 2'b00, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 10};
        vecs[3] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 1, 0, 0, 0, 0, 2'b10, 32'h1234_5678, 32'h1234_5678, 1'b1, 4};
        vecs[4] = '{1'b1, 32'h0000_0100, 32'h1111_2222, 4'h3, 0, 0, 0, 0, 0, 2'b00, 32'h0,         32'h1234_5678, 1'b0, 3};
        vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'h3333_4444, 4'hC, 0, 0, 0, 2, 0, 2'b11, 32'h0,         32'h1234_5678, 1'b1, 5};
        vecs[6] = '{1'b1, 32'h2000_0000, 32'h5555_6666, 4'h1, 0, 0, 1, 1, 2, 2'b01, 32'h0,         32'h1234_5678, 1'b0, 6};
        vecs[7] = '{1'b0, 32'h4000_0008, 32'h0,         4'h0, 0, 3, 0, 0, 0, 2'b01, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 6};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk("reset.outputs",
            64'({req_ready_o, arvalid_o, rready_o, awvalid_o, wvalid_o, wlast_o, bready_o,
                 resp_valid_o, resp_err_o}), 64'b1_0000_0000);
        chk("reset.rdata", 64'(resp_rdata_o), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
            if (!vecs[i].we) model_rdata = vecs[i].rdata;
        end

        // reset while waiting for the write response
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h9000_0000;
        req_wdata_i = 32'h7777_8888; req_wstrb_i = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        awready_i = 1'b1; wready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awready_i = 1'b0; wready_i = 1'b0;
        chk("rst_wrb.in_wr_b", 64'({bready_o, awvalid_o, wvalid_o}), 64'b100);
        rstn = 1'b0; bvalid_i = 1'b1; bresp_i = 2'b10;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1; slave_idle();
        chk("rst_wrb.outputs",
            64'({req_ready_o, arvalid_o, rready_o, awvalid_o, wvalid_o, wlast_o, bready_o,
                 resp_valid_o, resp_err_o}), 64'b1_0000_0000);
        chk("rst_wrb.rdata", 64'(resp_rdata_o), 64'd0);
        quiet = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid_o !== 1'b0) quiet++;
        end
        chk("rst_wrb.no_resp", 64'(quiet), 64'd0);
        model_rdata = '0;
        t = '{1'b0, 32'h8000_0040, 32'h0, 4'h0, 0, 1, 0, 0, 0, 2'b00, 32'hFEED_FACE,
              32'h0, 1'b0, 0};
        t = ref_model(t, model_rdata);
        run_txn(t, "rst_wrb.read_after");
        model_rdata = t.rdata;

        for (int i = 0; i < 40; i++) begin
            t.we    = 1'($urandom);
            t.addr  = $urandom;
            t.wdata = $urandom;
            t.wstrb = 4'($urandom);
            t.ar_d  = $urandom_range(0, 4);
            t.r_d   = $urandom_range(0, 4);
            t.aw_d  = $urandom_range(0, 4);
            t.w_d   = $urandom_range(0, 4);
            t.b_d   = $urandom_range(0, 4);
            t.resp  = 2'($urandom);
            t.rdata = $urandom;
            t = ref_model(t, model_rdata);
            run_txn(t, $sformatf("rand%0d", i));
            if (!t.we) model_rdata = t.rdata;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
